// File: rtl/configurable_division_pkg.sv
// configurable_division_pkg: mode codes, lane widths, FSM states and abs helpers shared by the divider
package configurable_division_pkg;
  localparam logic [1:0] CM_SINGLE8  = 2'b00;
  localparam logic [1:0] CM_PAR8     = 2'b01;
  localparam logic [1:0] CM_SINGLE16 = 2'b10;
  localparam int LANE8  = 8;
  localparam int LANE16 = 16;
  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
  // Magnitude of a signed value; the most negative value maps to 2^(N-1) as unsigned
  function automatic logic [7:0] abs8(input logic [7:0] x);
    return x[7] ? -x : x;
  endfunction
  function automatic logic [15:0] abs16(input logic [15:0] x);
    return x[15] ? -x : x;
  endfunction
endpackage

// File: rtl/configurable_division_step.sv
// div_step: one combinational restoring-division step over 16 bits, optionally split into two 8-bit lanes
// Ports: rem_i/quo_i partial remainder and dividend/quotient shift register, den_i divisor magnitude(s),
//        split_i breaks the bit-7/8 boundary, rem_o/quo_o state after the step.
module div_step (
  input  logic [15:0] rem_i,
  input  logic [15:0] quo_i,
  input  logic [15:0] den_i,
  input  logic        split_i,
  output logic [15:0] rem_o,
  output logic [15:0] quo_o
);
  logic [15:0] rs, qs;
  logic [8:0]  tl, th;
  logic        okl, okh;
  always_comb begin
    rs  = split_i ? {rem_i[14:8], quo_i[15], rem_i[6:0], quo_i[7]} : {rem_i[14:0], quo_i[15]};
    qs  = split_i ? {quo_i[14:8], 1'b0, quo_i[6:0], 1'b0} : {quo_i[14:0], 1'b0};
    tl  = {1'b0, rs[7:0]} - {1'b0, den_i[7:0]};
    // Low-byte borrow feeds the high byte only when the lanes are joined
    th  = {1'b0, rs[15:8]} - {1'b0, den_i[15:8]} - {8'h00, ~split_i & tl[8]};
    okh = ~th[8];
    okl = split_i ? ~tl[8] : ~th[8];
    rem_o = {okh ? th[7:0] : rs[15:8], okl ? tl[7:0] : rs[7:0]};
    quo_o = qs | {7'h00, split_i & okh, 7'h00, okl};
  end
endmodule

// File: rtl/configurable_division.sv
// configurable_division: signed iterative restoring divider, single 8-bit, dual 8-bit or single 16-bit
// Ports: clk_i clock, reset_ni async active-low reset, dividend_i/divisor_i signed operands,
//        enable_i start request, cm_i mode, result_o packed quotient/remainder,
//        data_valid_o result valid, div_by_zero_o an active lane divided by zero.
module configurable_division
  import configurable_division_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [15:0] dividend_i,
  input  logic [15:0] divisor_i,
  input  logic        enable_i,
  input  logic [1:0]  cm_i,
  output logic [31:0] result_o,
  output logic        data_valid_o,
  output logic        div_by_zero_o
);
  state_t      state_q;
  logic        wide_q, par_q, valid_q, dbz_q;
  logic [1:0]  sd_q, sq_q, z_q;
  logic [15:0] rem_q, quo_q, den_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;
  logic        wide_d, par_d, dbz_d;
  logic [1:0]  sd_d, sq_d, z_d;
  logic [15:0] rem_d, quo_d, quo0_d, den0_d, q16, r16;
  logic [7:0]  qh, rh, ql, rl;
  logic [31:0] result_d;
  div_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .den_i  (den_q),
    .split_i(~wide_q),
    .rem_o  (rem_d),
    .quo_o  (quo_d)
  );
  // Mode 11 behaves as 16-bit; in single 8-bit mode lane H is zeroed and never reported
  always_comb begin
    wide_d = cm_i[1];
    par_d  = cm_i == CM_PAR8;
    quo0_d = wide_d ? abs16(dividend_i) : {par_d ? abs8(dividend_i[15:8]) : 8'h00, abs8(dividend_i[7:0])};
    den0_d = wide_d ? abs16(divisor_i) : {par_d ? abs8(divisor_i[15:8]) : 8'h00, abs8(divisor_i[7:0])};
    sd_d   = wide_d ? {2{dividend_i[15]}} : {dividend_i[15], dividend_i[7]};
    sq_d   = wide_d ? {2{dividend_i[15] ^ divisor_i[15]}}
                    : {dividend_i[15] ^ divisor_i[15], dividend_i[7] ^ divisor_i[7]};
    z_d    = wide_d ? {2{divisor_i == 16'h0000}} : {divisor_i[15:8] == 8'h00, divisor_i[7:0] == 8'h00};
  end
  // Sign fix-up; a zero divisor forces the quotient to -1 while the remainder already equals |dividend|
  always_comb begin
    q16 = z_q[0] ? 16'hFFFF : sq_q[0] ? -quo_q : quo_q;
    r16 = sd_q[0] ? -rem_q : rem_q;
    qh  = z_q[1] ? 8'hFF : sq_q[1] ? -quo_q[15:8] : quo_q[15:8];
    rh  = sd_q[1] ? -rem_q[15:8] : rem_q[15:8];
    ql  = z_q[0] ? 8'hFF : sq_q[0] ? -quo_q[7:0] : quo_q[7:0];
    rl  = sd_q[0] ? -rem_q[7:0] : rem_q[7:0];
    result_d = wide_q ? {q16, r16} : par_q ? {qh, rh, ql, rl} : {16'h0000, ql, rl};
    dbz_d    = par_q ? |z_q : z_q[0];
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      wide_q   <= 1'b0;
      par_q    <= 1'b0;
      sd_q     <= 2'b00;
      sq_q     <= 2'b00;
      z_q      <= 2'b00;
      rem_q    <= 16'h0000;
      quo_q    <= 16'h0000;
      den_q    <= 16'h0000;
      cnt_q    <= 5'd0;
      result_q <= 32'h0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (enable_i) begin
          wide_q  <= wide_d;
          par_q   <= par_d;
          sd_q    <= sd_d;
          sq_q    <= sq_d;
          z_q     <= z_d;
          rem_q   <= 16'h0000;
          quo_q   <= quo0_d;
          den_q   <= den0_d;
          cnt_q   <= wide_d ? 5'(LANE16 - 1) : 5'(LANE8 - 1);
          valid_q <= 1'b0;
          dbz_q   <= 1'b0;
          state_q <= DIV;
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= FIX;
        end
        FIX: begin
          result_q <= result_d;
          valid_q  <= 1'b1;
          dbz_q    <= dbz_d;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign result_o      = result_q;
  assign data_valid_o  = valid_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_configurable_division.sv
// tb_configurable_division: directed self-checking bench for configurable_division
module tb_configurable_division;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dividend = 16'h0;
  logic [15:0] divisor = 16'h0;
  logic        en = 1'b0;
  logic [1:0]  cm = 2'b00;
  logic [31:0] result;
  logic        valid, dbz;
  int          nvec = 0;
  int          nerr = 0;
  configurable_division dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .enable_i     (en),
    .cm_i         (cm),
    .result_o     (result),
    .data_valid_o (valid),
    .div_by_zero_o(dbz)
  );
  always #5 clk = ~clk;
  task automatic wait_valid(input int k0, output int lat);
    lat = 0;
    for (int k = k0 + 1; k <= k0 + 40; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic start(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    cm = m;
    dividend = a;
    divisor = b;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    nvec++; if (result !== 32'h0) begin nerr++; $display("FAIL reset_result got %h want 00000000", result); end
    nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", valid); end
    nvec++; if (dbz !== 1'b0) begin nerr++; $display("FAIL reset_dbz got %b want 0", dbz); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_mode16();
    int lat;
    start(2'b10, 16'h1BF7, 16'hFFDF);
    wait_valid(0, lat);
    nvec++; if (lat !== 17) begin nerr++; $display("FAIL m16_latency got %0d want 17", lat); end
    nvec++; if (result !== 32'hFF28001F) begin nerr++; $display("FAIL m16_result got %h want FF28001F", result); end
    nvec++; if (dbz !== 1'b0) begin nerr++; $display("FAIL m16_dbz got %b want 0", dbz); end
    @(posedge clk);
    #1;
    nvec++; if (valid !== 1'b1 || result !== 32'hFF28001F) begin nerr++; $display("FAIL m16_hold got %b/%h want 1/FF28001F", valid, result); end
  endtask
  task automatic test_par8();
    int lat;
    start(2'b01, 16'h9C64, 16'h07F7);
    wait_valid(0, lat);
    nvec++; if (lat !== 9) begin nerr++; $display("FAIL par8_latency got %0d want 9", lat); end
    nvec++; if (result !== 32'hF2FEF501) begin nerr++; $display("FAIL par8_result got %h want F2FEF501", result); end
    nvec++; if (dbz !== 1'b0) begin nerr++; $display("FAIL par8_dbz got %b want 0", dbz); end
  endtask
  task automatic test_single8();
    int lat;
    start(2'b00, 16'h1280, 16'h34FF);
    wait_valid(0, lat);
    nvec++; if (lat !== 9) begin nerr++; $display("FAIL s8_latency got %0d want 9", lat); end
    nvec++; if (result !== 32'h00008000) begin nerr++; $display("FAIL s8_result got %h want 00008000", result); end
    start(2'b11, 16'h8000, 16'hFFFF);
    wait_valid(0, lat);
    nvec++; if (result !== 32'h80000000 || lat !== 17) begin nerr++; $display("FAIL m11_ovf got %h/%0d want 80000000/17", result, lat); end
  endtask
  task automatic test_div_zero();
    int lat;
    start(2'b10, 16'h04D2, 16'h0000);
    wait_valid(0, lat);
    nvec++; if (lat !== 17) begin nerr++; $display("FAIL dz_latency got %0d want 17", lat); end
    nvec++; if (result !== 32'hFFFF04D2) begin nerr++; $display("FAIL dz_result got %h want FFFF04D2", result); end
    nvec++; if (dbz !== 1'b1) begin nerr++; $display("FAIL dz_flag got %b want 1", dbz); end
    start(2'b01, 16'hF6EC, 16'h0004);
    wait_valid(0, lat);
    nvec++; if (result !== 32'hFFF6FB00 || dbz !== 1'b1) begin nerr++; $display("FAIL dz_par got %h/%b want FFF6FB00/1", result, dbz); end
  endtask
  task automatic test_reset_mid();
    int lat;
    start(2'b10, 16'h0100, 16'h0003);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if (result !== 32'h0 || valid !== 1'b0 || dbz !== 1'b0) begin nerr++; $display("FAIL rst_mid got %h/%b/%b want 00000000/0/0", result, valid, dbz); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(0, lat);
    nvec++; if (lat !== 0) begin nerr++; $display("FAIL rst_abort got valid after %0d want none", lat); end
    start(2'b10, 16'd100, 16'd10);
    wait_valid(0, lat);
    nvec++; if (result !== 32'h000A0000 || lat !== 17) begin nerr++; $display("FAIL rst_after got %h/%0d want 000A0000/17", result, lat); end
  endtask
  task automatic test_back_to_back();
    int lat;
    start(2'b10, 16'd1000, 16'd7);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    cm = 2'b00;
    dividend = 16'h0005;
    divisor = 16'h0005;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_valid(4, lat);
    nvec++; if (lat !== 17) begin nerr++; $display("FAIL ign_latency got %0d want 17", lat); end
    nvec++; if (result !== 32'h008E0006) begin nerr++; $display("FAIL ign_result got %h want 008E0006", result); end
    cm = 2'b00;
    dividend = 16'h0064;
    divisor = 16'h0007;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL b2b_drop got %b want 0", valid); end
    nvec++; if (result !== 32'h008E0006) begin nerr++; $display("FAIL b2b_keep got %h want 008E0006", result); end
    wait_valid(0, lat);
    nvec++; if (lat !== 9) begin nerr++; $display("FAIL b2b_latency got %0d want 9", lat); end
    nvec++; if (result !== 32'h00000E02) begin nerr++; $display("FAIL b2b_result got %h want 00000E02", result); end
  endtask
  initial begin
    test_reset();
    test_mode16();
    test_par8();
    test_single8();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/configurable_division.md
Name: configurable_division

Overview:
- Signed iterative divider; inverse operation of configurable_multiplication.
- Supports the same three modes and is selected by the same cm_i encoding.
- Sits behind the same AXI-lite slave register wrapper:
  - slv_reg0 carries reset, enable and mode.
  - slv_reg1 carries the operands.
  - slv_reg2 and slv_reg3 capture the result and done.
- Restoring division, one quotient bit per clock. In parallel mode the 16-bit datapath splits into two independent 8-bit lanes.

Parameters:
- None. Widths are fixed by the register map: 16-bit operands, 32-bit result.

Ports:
- clk_i  input  1  rising-edge clock.
- reset_ni  input  1  asynchronous active-low reset.
- dividend_i  input  16  signed dividend(s); driven from slv_reg1[31:16].
- divisor_i  input  16  signed divisor(s); driven from slv_reg1[15:0].
- enable_i  input  1  start request, level-sampled.
- cm_i  input  2  mode select:
  - 00 = single 8-bit, using bits [7:0].
  - 01 = two parallel 8-bit: lane H = [15:8], lane L = [7:0].
  - 10 = single 16-bit.
  - 11 = reserved, treated as 10.
- result_o  output  32  packed quotient/remainder (layout in Behaviour).
- data_valid_o  output  1  result valid.
- div_by_zero_o  output  1  at least one active lane had a zero divisor.

Behaviour:
- Reset: async, while reset_ni = 0:
  - state = IDLE.
  - result_o = 0, data_valid_o = 0, div_by_zero_o = 0.
  - All internal registers cleared.
  - Reset mid-operation aborts the operation with no result.
- FSM states: IDLE, DIV, FIX, DONE.
- Start:
  - In IDLE or DONE, enable_i sampled 1 at edge N starts an operation.
  - Edge N captures cm_i, the operand signs, the absolute values, and the zero-divisor flags.
  - Sets iteration count W (16 for mode 10/11, 8 otherwise).
  - Clears data_valid_o and div_by_zero_o.
  - Moves to DIV.
- DIV:
  - Edges N+1 .. N+W each perform one restoring step: shift remainder/quotient, trial-subtract, restore on negative.
  - In mode 01 the subtractor carry between bits 7 and 8 is broken, so lanes H and L step simultaneously.
  - Transitions to FIX after step W.
- FIX (edge N+W+1):
  - Quotient is negated when the dividend sign differs from the divisor sign; remainder takes the dividend sign.
  - Register result_o, set data_valid_o = 1, set div_by_zero_o, go to DONE.
  - Latency from the start edge to data_valid_o high: 17 cycles for 16-bit, 9 cycles for 8-bit modes.
- DONE:
  - result_o, data_valid_o and div_by_zero_o are held until the next start or reset.
  - enable_i held at 1 in DONE starts a new operation on the next edge; data_valid_o is low for at least W+1 cycles.
- enable_i while in DIV or FIX is ignored. Changes to cm_i or the operands after the start edge are ignored.
- Rounding: truncation toward zero. Remainder sign equals dividend sign. Invariant: dividend = q*divisor + r.
- result_o layout:
  - mode 10: {q16, r16}.
  - mode 01: {qH8, rH8, qL8, rL8}.
  - mode 00: {16'h0000, q8, r8}.
- Divide by zero (per lane):
  - quotient = all ones (−1), remainder = dividend.
  - div_by_zero_o = 1.
  - Latency unchanged.
- Overflow (per lane):
  - −32768 / −1 gives q = 0x8000, r = 0.
  - −128 / −1 gives q = 0x80, r = 0.
  - Wraps; no flag.
- Mode 00: dividend_i[15:8] and divisor_i[15:8] are ignored.

Decomposition:
- Package configurable_division_pkg holds:
  - Mode constants CM_SINGLE8 = 2'b00, CM_PAR8 = 2'b01, CM_SINGLE16 = 2'b10.
  - State encoding.
  - Lane widths 8 and 16.
- One sub-module, div_step:
  - Combinational 16-bit restoring step (shift, trial subtract, restore).
  - Has a split_i input that breaks the bit-7/8 boundary for parallel mode.
  - Instantiated once.

Test Plan:
1. Mode 10: dividend 7159 (0x1BF7), divisor −33 (0xFFDF).
   - result_o = 0xFF28001F (q = −216, r = 31).
   - data_valid_o rises 17 cycles after the start edge.
   - div_by_zero_o = 0.
2. Mode 01: dividend_i = 0x9C64, divisor_i = 0x07F7.
   - Lane H: −100/7. Lane L: 100/−9.
   - result_o = 0xF2FEF501 after 9 cycles.
3. Mode 00: dividend_i = 0x1280, divisor_i = 0x34FF (−128/−1).
   - result_o = 0x00008000, with the upper operand bytes ignored.
4. Mode 10: dividend 0x04D2, divisor 0x0000.
   - result_o = 0xFFFF04D2, div_by_zero_o = 1, latency 17 cycles.
5. Reset mid-operation: start mode 10, pull reset_ni low at cycle 5 with no clock edge.
   - result_o, data_valid_o and div_by_zero_o go to 0 immediately.
   - After release, a new 100/10 in mode 10 gives 0x000A0000.
6. Pulse enable_i high during DIV: the operation continues with its original operands.
   - Then hold enable_i high in DONE: data_valid_o drops on the next edge and a new result appears W+1 cycles later.
